// File: rtl/alu_arbiter_if.sv
// Bundle of the two requester ports, the shared-ALU port and the response
// port of alu_arbiter. The arbiter connects through the slave modport; the
// requesters, the ALU and the response consumer sit on the master side.
interface alu_arbiter_if;
    // Requester 0
    logic        req0_valid;
    logic        req0_ready;
    logic [31:0] req0_a;
    logic [31:0] req0_b;
    logic        req0_ipsel;
    logic [4:0]  req0_opsel;
    // Requester 1
    logic        req1_valid;
    logic        req1_ready;
    logic [31:0] req1_a;
    logic [31:0] req1_b;
    logic        req1_ipsel;
    logic [4:0]  req1_opsel;
    // Shared combinational ALU
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic        alu_ipsel;
    logic [4:0]  alu_opsel;
    logic [31:0] alu_result;
    logic        alu_carry;
    // Response
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_id;
    logic [31:0] rsp_result;
    logic        rsp_carry;

    modport master (
        output req0_valid, req0_a, req0_b, req0_ipsel, req0_opsel,
        output req1_valid, req1_a, req1_b, req1_ipsel, req1_opsel,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_ipsel, alu_opsel,
        output alu_result, alu_carry,
        input  rsp_valid, rsp_id, rsp_result, rsp_carry,
        output rsp_ready
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_ipsel, req0_opsel,
        input  req1_valid, req1_a, req1_b, req1_ipsel, req1_opsel,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_ipsel, alu_opsel,
        input  alu_result, alu_carry,
        output rsp_valid, rsp_id, rsp_result, rsp_carry,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of one shared combinational ALU.
// One operation is in flight at a time: IDLE grants, EXEC waits EXEC_CYCLES
// for the ALU to settle, RESP holds the captured result until the consumer
// takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. reqN_ready is combinational and only ever 1 in IDLE for the winner;
// rsp_valid is 1 exactly in RESP and the response payload is held stable
// until rsp_ready is seen high.
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1   // ALU settle cycles, 1..15
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_arbiter_if.slave       bus,
    output logic [1:0]         dbg_state     // 0 = IDLE, 1 = EXEC, 2 = RESP
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic        last_id;      // requester granted most recently
    logic [3:0]  cnt;          // remaining settle cycles minus one
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        op_ipsel;
    logic [4:0]  op_opsel;
    logic        op_id;
    logic [31:0] rsp_result_q;
    logic        rsp_carry_q;
    logic        rsp_id_q;
    logic        grant;
    logic        grant_id;
    logic        capture;

    // Next-state and grant decision; a tie goes to the requester not served last
    always_comb begin
        state_next = state;
        grant      = 1'b0;
        grant_id   = 1'b0;
        capture    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.req0_valid && bus.req1_valid) begin
                    grant    = 1'b1;
                    grant_id = ~last_id;
                end else if (bus.req0_valid) begin
                    grant    = 1'b1;
                    grant_id = 1'b0;
                end else if (bus.req1_valid) begin
                    grant    = 1'b1;
                    grant_id = 1'b1;
                end
                if (grant) begin
                    state_next = EXEC;
                end
            end
            EXEC: begin
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                // The handshake edge only returns to IDLE; the next grant
                // needs a fresh IDLE cycle.
                if (bus.rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operand latch, round-robin pointer and settle counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_id  <= 1'b1;   // so requester 0 wins the first tie
            cnt      <= 4'd0;
            op_a     <= 32'd0;
            op_b     <= 32'd0;
            op_ipsel <= 1'b0;
            op_opsel <= 5'd0;
            op_id    <= 1'b0;
        end else if (grant) begin
            last_id  <= grant_id;
            cnt      <= CNT_LOAD;
            op_id    <= grant_id;
            op_a     <= grant_id ? bus.req1_a     : bus.req0_a;
            op_b     <= grant_id ? bus.req1_b     : bus.req0_b;
            op_ipsel <= grant_id ? bus.req1_ipsel : bus.req0_ipsel;
            op_opsel <= grant_id ? bus.req1_opsel : bus.req0_opsel;
        end else if (state == EXEC && cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end
    end

    // Response capture once the ALU has settled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_result_q <= 32'd0;
            rsp_carry_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
        end else if (capture) begin
            rsp_result_q <= bus.alu_result;
            rsp_carry_q  <= bus.alu_carry;
            rsp_id_q     <= op_id;
        end
    end

    // Ready is masked by reset so nothing looks accepted while rst_n is low
    assign bus.req0_ready = rst_n & grant & ~grant_id;
    assign bus.req1_ready = rst_n & grant &  grant_id;

    // The ALU always sees the operand registers, independent of requester inputs
    assign bus.alu_a      = op_a;
    assign bus.alu_b      = op_b;
    assign bus.alu_ipsel  = op_ipsel;
    assign bus.alu_opsel  = op_opsel;

    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_carry  = rsp_carry_q;

    assign dbg_state      = state;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter. Two instances run side by side:
// dut1 with EXEC_CYCLES=1 and dut3 with EXEC_CYCLES=3, each with its own
// interface and its own behavioural ALU.
module tb_alu_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] dbg1;
    logic [1:0] dbg3;
    int         checks = 0;
    int         failures = 0;

    // Expected responses, packed as {id, carry, result}
    logic [33:0] exp_q[$];

    always #5 clk = ~clk;

    alu_arbiter_if bus1();
    alu_arbiter_if bus3();

    alu_arbiter #(.EXEC_CYCLES(1)) dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus1.slave),
        .dbg_state (dbg1)
    );

    alu_arbiter #(.EXEC_CYCLES(3)) dut3 (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus3.slave),
        .dbg_state (dbg3)
    );

    // Behavioural ALU: {carry, result}. ipsel swaps the operands.
    function automatic logic [32:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                           input logic ipsel, input logic [4:0] opsel);
        logic [31:0] x;
        logic [31:0] y;
        x = ipsel ? b : a;
        y = ipsel ? a : b;
        case (opsel)
            5'd1:    return {1'b0, x} + {1'b0, y};
            5'd2:    return {1'b0, x} - {1'b0, y};
            5'd3:    return {1'b0, x & y};
            5'd4:    return {1'b0, x | y};
            5'd5:    return {1'b0, x ^ y};
            default: return {1'b0, x};
        endcase
    endfunction

    assign {bus1.alu_carry, bus1.alu_result} = alu_fn(bus1.alu_a, bus1.alu_b, bus1.alu_ipsel, bus1.alu_opsel);
    assign {bus3.alu_carry, bus3.alu_result} = alu_fn(bus3.alu_a, bus3.alu_b, bus3.alu_ipsel, bus3.alu_opsel);

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    // ---------------- driver tasks ----------------
    task automatic idle_inputs();
        bus1.req0_valid = 0; bus1.req0_a = 0; bus1.req0_b = 0; bus1.req0_ipsel = 0; bus1.req0_opsel = 0;
        bus1.req1_valid = 0; bus1.req1_a = 0; bus1.req1_b = 0; bus1.req1_ipsel = 0; bus1.req1_opsel = 0;
        bus1.rsp_ready  = 1;
        bus3.req0_valid = 0; bus3.req0_a = 0; bus3.req0_b = 0; bus3.req0_ipsel = 0; bus3.req0_opsel = 0;
        bus3.req1_valid = 0; bus3.req1_a = 0; bus3.req1_b = 0; bus3.req1_ipsel = 0; bus3.req1_opsel = 0;
        bus3.rsp_ready  = 1;
    endtask

    // Leaves the bench at a falling edge with reset just released
    task automatic do_reset();
        @(negedge clk);
        rst_n = 0;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst_n = 1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        bus1.req0_valid = 1;
        bus3.req1_valid = 1;
        bus1.req0_a = 32'h1234;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus1.req0_ready, bus1.req1_ready, bus3.req0_ready, bus3.req1_ready} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready: got %b expected 0000",
                     {bus1.req0_ready, bus1.req1_ready, bus3.req0_ready, bus3.req1_ready});
        end
        checks++;
        if ({bus1.rsp_valid, bus3.rsp_valid} !== 2'b00) begin
            failures++;
            $display("FAIL reset_rsp_valid: got %b expected 00", {bus1.rsp_valid, bus3.rsp_valid});
        end
        checks++;
        if ({bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result} !== 34'd0) begin
            failures++;
            $display("FAIL reset_rsp_payload: got %h expected 0", {bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result});
        end
        checks++;
        if ({bus1.alu_a, bus1.alu_b, bus1.alu_ipsel, bus1.alu_opsel} !== 70'd0 ||
            {bus3.alu_a, bus3.alu_b, bus3.alu_ipsel, bus3.alu_opsel} !== 70'd0) begin
            failures++;
            $display("FAIL reset_operands: dut1 a=%h b=%h dut3 a=%h b=%h expected 0",
                     bus1.alu_a, bus1.alu_b, bus3.alu_a, bus3.alu_b);
        end
        checks++;
        if (dbg1 !== 2'd0 || dbg3 !== 2'd0) begin
            failures++;
            $display("FAIL reset_state: got %0d/%0d expected 0/0", dbg1, dbg3);
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1;
    endtask

    task automatic test_single();
        do_reset();
        bus1.rsp_ready = 0;
        bus1.req0_valid = 1; bus1.req0_a = 5; bus1.req0_b = 7; bus1.req0_ipsel = 0; bus1.req0_opsel = 5'b00001;
        #1;
        checks++;
        if ({bus1.req0_ready, bus1.req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL single_grant: ready0/1 got %b expected 10", {bus1.req0_ready, bus1.req1_ready});
        end
        @(negedge clk);
        bus1.req0_valid = 0;
        #1;
        checks++;
        if (bus1.rsp_valid !== 1'b0 || bus1.req0_ready !== 1'b0) begin
            failures++;
            $display("FAIL single_exec: rsp_valid=%b ready0=%b expected 0 0", bus1.rsp_valid, bus1.req0_ready);
        end
        @(negedge clk);
        #1;
        checks++;
        if ({bus1.rsp_valid, bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result} !== {1'b1, 1'b0, 1'b0, 32'd12}) begin
            failures++;
            $display("FAIL single_rsp: valid=%b id=%b carry=%b result=%0d expected 1 0 0 12",
                     bus1.rsp_valid, bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result);
        end
        bus1.rsp_ready = 1;
        @(negedge clk);
        #1;
        checks++;
        if (bus1.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_release: rsp_valid got %b expected 0", bus1.rsp_valid);
        end
    endtask

    task automatic test_round_robin();
        int n_grants;
        logic [32:0] r;
        do_reset();
        exp_q.delete();
        n_grants = 0;
        bus1.rsp_ready = 1;
        bus1.req0_valid = 1; bus1.req0_a = 100; bus1.req0_b = 1; bus1.req0_opsel = 5'd1;
        bus1.req1_valid = 1; bus1.req1_a = 200; bus1.req1_b = 2; bus1.req1_opsel = 5'd2;
        for (int cyc = 0; cyc <= 20; cyc++) begin
            #1;
            if (bus1.req0_ready || bus1.req1_ready) begin
                checks++;
                if ({bus1.req0_ready, bus1.req1_ready} !== {n_grants[0] == 1'b0, n_grants[0] == 1'b1} ||
                    cyc != 3 * n_grants) begin
                    failures++;
                    $display("FAIL rr_grant: grant %0d at cycle %0d ready=%b expected cycle %0d id %0d",
                             n_grants, cyc, {bus1.req0_ready, bus1.req1_ready}, 3 * n_grants, n_grants % 2);
                end
                if (bus1.req1_ready) begin
                    r = alu_fn(200, 2, 0, 5'd2);
                    exp_q.push_back({1'b1, r});
                end else begin
                    r = alu_fn(100, 1, 0, 5'd1);
                    exp_q.push_back({1'b0, r});
                end
                n_grants++;
            end
            if (bus1.rsp_valid) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL rr_rsp: unexpected response id=%b result=%h", bus1.rsp_id, bus1.rsp_result);
                end else if ({bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL rr_rsp: got %h expected %h", {bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result}, exp_q[0]);
                    void'(exp_q.pop_front());
                end else begin
                    void'(exp_q.pop_front());
                end
            end
            @(negedge clk);
        end
        checks++;
        if (n_grants != 7) begin
            failures++;
            $display("FAIL rr_count: got %0d grants expected 7", n_grants);
        end
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_backpressure();
        logic [33:0] exp;
        int n;
        do_reset();
        bus1.rsp_ready = 0;
        bus1.req1_valid = 1; bus1.req1_a = $urandom; bus1.req1_b = $urandom;
        bus1.req1_ipsel = 1'($urandom_range(0, 1)); bus1.req1_opsel = 5'($urandom_range(1, 5));
        exp = {1'b1, alu_fn(bus1.req1_a, bus1.req1_b, bus1.req1_ipsel, bus1.req1_opsel)};
        #1;
        checks++;
        if (bus1.req1_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_grant: ready1 got %b expected 1", bus1.req1_ready);
        end
        @(negedge clk);
        bus1.req1_valid = 0;
        n = 0;
        #1;
        while (!bus1.rsp_valid && n < 10) begin
            @(negedge clk);
            #1;
            n++;
        end
        checks++;
        if (n != 1) begin
            failures++;
            $display("FAIL bp_latency: rsp_valid after %0d cycles expected 1", n);
        end
        bus1.req0_valid = 1; bus1.req0_a = $urandom;
        bus1.req1_valid = 1; bus1.req1_a = $urandom;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus1.rsp_valid !== 1'b1 || {bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result} !== exp ||
                {bus1.req0_ready, bus1.req1_ready} !== 2'b00) begin
                failures++;
                $display("FAIL bp_hold: cycle %0d valid=%b rsp=%h ready=%b expected 1 %h 00", i,
                         bus1.rsp_valid, {bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result}, exp,
                         {bus1.req0_ready, bus1.req1_ready});
            end
            @(negedge clk);
            #1;
        end
        bus1.rsp_ready = 1;
        #1;
        checks++;
        if (bus1.rsp_valid !== 1'b1 || {bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result} !== exp ||
            {bus1.req0_ready, bus1.req1_ready} !== 2'b00) begin
            failures++;
            $display("FAIL bp_accept: valid=%b rsp=%h ready=%b expected 1 %h 00", bus1.rsp_valid,
                     {bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result}, exp, {bus1.req0_ready, bus1.req1_ready});
        end
        @(negedge clk);
        #1;
        checks++;
        if (bus1.rsp_valid !== 1'b0 || {bus1.req0_ready, bus1.req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL bp_next_grant: valid=%b ready=%b expected 0 10", bus1.rsp_valid,
                     {bus1.req0_ready, bus1.req1_ready});
        end
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    task automatic test_exec3();
        do_reset();
        bus3.rsp_ready = 0;
        bus3.req1_valid = 1; bus3.req1_a = 32'hFFFF_FFFF; bus3.req1_b = 32'd1; bus3.req1_ipsel = 0; bus3.req1_opsel = 5'b00001;
        #1;
        checks++;
        if ({bus3.req0_ready, bus3.req1_ready} !== 2'b01) begin
            failures++;
            $display("FAIL exec3_grant: ready got %b expected 01", {bus3.req0_ready, bus3.req1_ready});
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus3.req1_valid = 0;
            bus3.req1_a = $urandom;
            bus3.req0_valid = (k < 4);
            bus3.req0_a = $urandom;
            #1;
            checks++;
            if ({bus3.alu_a, bus3.alu_b, bus3.alu_ipsel, bus3.alu_opsel} !== {32'hFFFF_FFFF, 32'd1, 1'b0, 5'd1} ||
                {bus3.req0_ready, bus3.req1_ready} !== 2'b00 || bus3.rsp_valid !== (k == 4)) begin
                failures++;
                $display("FAIL exec3_cycle: k=%0d alu_a=%h alu_b=%h ready=%b rsp_valid=%b expected ffffffff 1 00 %b",
                         k, bus3.alu_a, bus3.alu_b, {bus3.req0_ready, bus3.req1_ready}, bus3.rsp_valid, k == 4);
            end
        end
        checks++;
        if ({bus3.rsp_id, bus3.rsp_carry, bus3.rsp_result} !== {1'b1, 1'b1, 32'd0}) begin
            failures++;
            $display("FAIL exec3_rsp: id=%b carry=%b result=%h expected 1 1 0", bus3.rsp_id, bus3.rsp_carry, bus3.rsp_result);
        end
        bus3.rsp_ready = 1;
        @(negedge clk);
        #1;
        checks++;
        if (bus3.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL exec3_release: rsp_valid got %b expected 0", bus3.rsp_valid);
        end
    endtask

    task automatic test_operand_change();
        @(negedge clk);
        bus3.rsp_ready = 1;
        bus3.req0_valid = 1; bus3.req0_a = 10; bus3.req0_b = 20; bus3.req0_ipsel = 0; bus3.req0_opsel = 5'd1;
        #1;
        checks++;
        if (bus3.req0_ready !== 1'b1) begin
            failures++;
            $display("FAIL opchg_grant: ready0 got %b expected 1", bus3.req0_ready);
        end
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            bus3.req0_valid = 0;
            bus3.req0_a = $urandom;
            #1;
            checks++;
            if (bus3.alu_a !== 32'd10 || bus3.rsp_valid !== (k == 4) ||
                (k == 4 && bus3.rsp_result !== 32'd30)) begin
                failures++;
                $display("FAIL opchg_cycle: k=%0d alu_a=%0d rsp_valid=%b result=%0d expected 10 %b 30",
                         k, bus3.alu_a, bus3.rsp_valid, bus3.rsp_result, k == 4);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_op();
        do_reset();
        // dut1 will sit in RESP and dut3 in EXEC when reset hits; both grant requester 0
        bus1.rsp_ready = 0;
        bus1.req0_valid = 1; bus1.req0_a = 32'hAAAA; bus1.req0_b = 32'h5555; bus1.req0_opsel = 5'd4;
        bus3.req0_valid = 1; bus3.req0_a = 32'h77; bus3.req0_b = 32'h1; bus3.req0_opsel = 5'd1;
        @(negedge clk);
        idle_inputs();
        bus1.rsp_ready = 0;
        @(negedge clk);
        #1;
        checks++;
        if (bus1.rsp_valid !== 1'b1 || bus3.rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL rst_mid_setup: rsp_valid dut1=%b dut3=%b expected 1 0", bus1.rsp_valid, bus3.rsp_valid);
        end
        rst_n = 0;
        #1;
        checks++;
        if (bus1.rsp_valid !== 1'b0 || bus3.rsp_valid !== 1'b0 || dbg1 !== 2'd0 || dbg3 !== 2'd0 ||
            bus1.rsp_result !== 32'd0 || bus3.alu_a !== 32'd0) begin
            failures++;
            $display("FAIL rst_mid_async: valid=%b/%b state=%0d/%0d result=%h alu_a=%h expected 0/0 0/0 0 0",
                     bus1.rsp_valid, bus3.rsp_valid, dbg1, dbg3, bus1.rsp_result, bus3.alu_a);
        end
        @(negedge clk);
        rst_n = 1;
        bus1.rsp_ready = 1;
        bus1.req0_valid = 1; bus1.req1_valid = 1;
        #1;
        checks++;
        if ({bus1.req0_ready, bus1.req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL rst_first_grant: ready got %b expected 10", {bus1.req0_ready, bus1.req1_ready});
        end
        bus1.req0_valid = 0; bus1.req1_valid = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            #1;
            checks++;
            if (bus3.rsp_valid !== 1'b0) begin
                failures++;
                $display("FAIL rst_no_rsp: cycle %0d rsp_valid got %b expected 0", k, bus3.rsp_valid);
            end
        end
        bus3.req0_valid = 1; bus3.req1_valid = 1;
        #1;
        checks++;
        if ({bus3.req0_ready, bus3.req1_ready} !== 2'b10) begin
            failures++;
            $display("FAIL rst_tie_after: ready got %b expected 10", {bus3.req0_ready, bus3.req1_ready});
        end
        idle_inputs();
        repeat (6) @(negedge clk);
    endtask

    // Random traffic on dut1 against a transaction-level model:
    // an accepted op yields its result EXEC_CYCLES cycles later and that
    // result waits until the consumer takes it; the arbiter only grants
    // when nothing is outstanding.
    task automatic test_random();
        localparam int EXEC = 1;
        logic        last_won;
        int          settle_left;
        logic        holding;
        logic [31:0] cur_a;
        logic [31:0] cur_b;
        logic        exp_r0;
        logic        exp_r1;
        logic [32:0] r;
        do_reset();
        exp_q.delete();
        last_won = 1'b1;
        settle_left = 0;
        holding = 1'b0;
        cur_a = 0;
        cur_b = 0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            bus1.req0_valid = ($urandom_range(0, 3) != 0);
            bus1.req1_valid = ($urandom_range(0, 3) != 0);
            bus1.req0_a = $urandom; bus1.req0_b = $urandom;
            bus1.req1_a = $urandom; bus1.req1_b = $urandom;
            bus1.req0_ipsel = 1'($urandom_range(0, 1)); bus1.req1_ipsel = 1'($urandom_range(0, 1));
            bus1.req0_opsel = 5'($urandom_range(0, 6)); bus1.req1_opsel = 5'($urandom_range(0, 6));
            bus1.rsp_ready = ($urandom_range(0, 2) != 0);
            #1;
            exp_r0 = 0;
            exp_r1 = 0;
            if (settle_left == 0 && !holding) begin
                if (bus1.req0_valid && bus1.req1_valid) begin
                    exp_r0 = last_won;
                    exp_r1 = !last_won;
                end else begin
                    exp_r0 = bus1.req0_valid;
                    exp_r1 = bus1.req1_valid;
                end
            end
            checks++;
            if ({bus1.req0_ready, bus1.req1_ready} !== {exp_r0, exp_r1}) begin
                failures++;
                $display("FAIL rand_ready: cycle %0d got %b expected %b", cyc, {bus1.req0_ready, bus1.req1_ready}, {exp_r0, exp_r1});
            end
            checks++;
            if (bus1.rsp_valid !== holding) begin
                failures++;
                $display("FAIL rand_rsp_valid: cycle %0d got %b expected %b", cyc, bus1.rsp_valid, holding);
            end
            if (holding && exp_q.size() != 0) begin
                checks++;
                if ({bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result} !== exp_q[0]) begin
                    failures++;
                    $display("FAIL rand_rsp: cycle %0d got %h expected %h", cyc,
                             {bus1.rsp_id, bus1.rsp_carry, bus1.rsp_result}, exp_q[0]);
                end
            end
            if (settle_left != 0 || holding) begin
                checks++;
                if (bus1.alu_a !== cur_a || bus1.alu_b !== cur_b) begin
                    failures++;
                    $display("FAIL rand_alu_hold: cycle %0d alu_a=%h alu_b=%h expected %h %h", cyc,
                             bus1.alu_a, bus1.alu_b, cur_a, cur_b);
                end
            end
            // advance the model across the coming edge
            if (holding) begin
                if (bus1.rsp_ready) begin
                    holding = 0;
                    void'(exp_q.pop_front());
                end
            end else if (settle_left != 0) begin
                settle_left--;
                if (settle_left == 0) holding = 1;
            end else if (exp_r0 || exp_r1) begin
                last_won = exp_r1;
                cur_a = exp_r1 ? bus1.req1_a : bus1.req0_a;
                cur_b = exp_r1 ? bus1.req1_b : bus1.req0_b;
                r = exp_r1 ? alu_fn(bus1.req1_a, bus1.req1_b, bus1.req1_ipsel, bus1.req1_opsel)
                           : alu_fn(bus1.req0_a, bus1.req0_b, bus1.req0_ipsel, bus1.req0_opsel);
                exp_q.push_back({exp_r1, r});
                settle_left = EXEC;
            end
        end
        idle_inputs();
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_exec3();
        test_operand_change();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter EXEC_CYCLES, default 1, meaning ALU settle cycles per operation; legal range 1..15.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0_valid / req1_valid  input  1  requester N presents an operation.
REQ-005 req0_ready / req1_ready  output  1  requester N operation accepted this cycle.
REQ-006 req0_a / req1_a  input  32  operand A of requester N.
REQ-007 req0_b / req1_b  input  32  operand B of requester N.
REQ-008 req0_ipsel / req1_ipsel  input  1  ALU input-select of requester N.
REQ-009 req0_opsel / req1_opsel  input  5  ALU op-select of requester N.
REQ-010 alu_a, alu_b  output  32  operands driven to the shared ALU.
REQ-011 alu_ipsel  output  1; alu_opsel  output  5  ALU control driven to the shared ALU.
REQ-012 alu_result  input  32; alu_carry  input  1  combinational ALU outputs.
REQ-013 rsp_valid  output  1  response holds a captured result.
REQ-014 rsp_ready  input  1  consumer accepts response.
REQ-015 rsp_id  output  1  requester that owns the response.
REQ-016 rsp_result  output  32; rsp_carry  output  1  captured ALU result and carry.

Function
REQ-017 FSM states IDLE, EXEC, RESP; exactly one active.
REQ-018 IDLE: if no reqN_valid, remain IDLE, both reqN_ready 0.
REQ-019 IDLE with one valid: that requester wins; with both valid: requester not granted last wins (round-robin pointer).
REQ-020 Winner's reqN_ready SHALL be 1 combinationally in that IDLE cycle only; loser's ready 0; ready never 1 outside IDLE.
REQ-021 On grant edge: latch winner's a, b, ipsel, opsel into operand registers, latch winner id, update pointer to winner, load cycle counter with EXEC_CYCLES-1, enter EXEC.
REQ-022 alu_a, alu_b, alu_ipsel, alu_opsel SHALL be the operand registers at all times (stable through EXEC and RESP).
REQ-023 EXEC: counter decrements each cycle; at the edge where counter is 0, capture alu_result into rsp_result, alu_carry into rsp_carry, winner id into rsp_id, enter RESP.
REQ-024 RESP: rsp_valid 1; rsp_id, rsp_result, rsp_carry stable until handshake.
REQ-025 RESP with rsp_ready 1: return to IDLE next edge; rsp_valid 0 in IDLE and EXEC.
REQ-026 No new grant in the same cycle as the RESP handshake; minimum op spacing = EXEC_CYCLES + 2 cycles.
REQ-027 opsel passed unmodified; arbiter SHALL not decode it; carry captured for every op.
REQ-028 reqN_valid dropping during EXEC/RESP has no effect on the in-flight operation.

Reset
REQ-029 rst_n low SHALL asynchronously force IDLE, pointer so requester 0 wins first tie, counter 0, operand registers 0, rsp_result 0, rsp_carry 0, rsp_id 0, rsp_valid 0, both ready 0.
REQ-030 Reset mid-EXEC or mid-RESP SHALL discard the operation; no response is produced after release.
REQ-031 First grant possible in the first clock edge after rst_n deasserts.

Verification
REQ-032 Single req0: a=5, b=7, ipsel=0, opsel=00001, EXEC_CYCLES=1, ALU model add -> req0_ready 1 one cycle, rsp_valid 2 cycles later, rsp_id 0, rsp_result 12, rsp_carry 0.
REQ-033 Both valid continuously, rsp_ready tied 1 -> grants alternate 0,1,0,1 starting with 0; each rsp_id matches its grant.
REQ-034 Backpressure: rsp_ready 0 for 5 cycles in RESP -> rsp_valid, rsp_result held constant, no ready to either requester, accept on 6th cycle.
REQ-035 EXEC_CYCLES=3, req1 a=32'hFFFFFFFF, b=1, opsel=00001 -> result captured exactly 3 cycles after grant, rsp_result 0, rsp_carry 1, alu_* stable throughout.
REQ-036 rst_n low during EXEC -> rsp_valid 0 immediately, state IDLE; after release with both valid, requester 0 granted first.
REQ-037 Operand change on req0_a after grant (EXEC) -> alu_a and rsp_result unaffected.
